// File: rtl/qlearn_episode_ctrl.sv
// rtl/qlearn_episode_ctrl.sv - Q-learning episode/step sequencer
//
// Drives training episodes from a latched start state. Every step it asks the
// policy/environment unit for an action and next state, reads the reward ROM
// at that next state, then offers the (state, action, next state, reward)
// tuple to the Q-update unit. Episodes end on the goal state or the step
// limit; the run ends after NUM_EPISODES episodes.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_start, i_init_state     start a run from i_init_state (IDLE only)
//   o_act_req, o_cur_st       action request for the current state
//   i_act_valid, i_action,
//   i_next_st                 policy/environment response
//   o_rom_st, i_rom_rt        reward ROM address / combinational read data
//   o_upd_valid, i_upd_ready  update tuple handshake
//   o_upd_st, o_upd_act,
//   o_upd_nst, o_upd_rt       update tuple payload
//   o_busy, o_done            run in progress / end-of-run pulse
//   o_step_cnt, o_epi_cnt     steps in current episode / episodes completed

module qlearn_episode_ctrl #(
  parameter int STATES_WIDTH  = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int STEP_WIDTH    = 8,
  parameter int EPI_WIDTH     = 8,
  parameter int MAX_STEPS     = 64,
  parameter int NUM_EPISODES  = 16,
  parameter int GOAL_STATE    = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [STATES_WIDTH-1:0]  i_init_state,
  output logic                     o_act_req,
  output logic [STATES_WIDTH-1:0]  o_cur_st,
  input  logic                     i_act_valid,
  input  logic [ACTIONS_WIDTH-1:0] i_action,
  input  logic [STATES_WIDTH-1:0]  i_next_st,
  output logic [STATES_WIDTH-1:0]  o_rom_st,
  input  logic [DATA_WIDTH-1:0]    i_rom_rt,
  output logic                     o_upd_valid,
  input  logic                     i_upd_ready,
  output logic [STATES_WIDTH-1:0]  o_upd_st,
  output logic [ACTIONS_WIDTH-1:0] o_upd_act,
  output logic [STATES_WIDTH-1:0]  o_upd_nst,
  output logic [DATA_WIDTH-1:0]    o_upd_rt,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [STEP_WIDTH-1:0]    o_step_cnt,
  output logic [EPI_WIDTH-1:0]     o_epi_cnt
);

  localparam logic [STATES_WIDTH-1:0] GOAL_C  = STATES_WIDTH'(GOAL_STATE);
  localparam logic [STEP_WIDTH-1:0]   MAX_C   = STEP_WIDTH'(MAX_STEPS);
  localparam logic [EPI_WIDTH-1:0]    NUM_C   = EPI_WIDTH'(NUM_EPISODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_RWD,
    S_UPD,
    S_CHK,
    S_DONE
  } state_t;

  state_t                   state;
  logic [STATES_WIDTH-1:0]  init_st;
  logic [STATES_WIDTH-1:0]  cur_st;
  logic [ACTIONS_WIDTH-1:0] act_r;
  logic [STATES_WIDTH-1:0]  nst_r;
  logic [DATA_WIDTH-1:0]    rt_r;
  logic [STEP_WIDTH-1:0]    step_cnt;
  logic [EPI_WIDTH-1:0]     epi_cnt;
  logic                     act_req_r;
  logic                     upd_valid_r;
  logic                     busy_r;
  logic                     done_r;

  // Goal is tested first, but either condition ends the episode exactly once,
  // so the OR is all the CHK state needs.
  logic                     episode_end;
  logic [EPI_WIDTH-1:0]     epi_next;

  assign episode_end = (nst_r == GOAL_C) || (step_cnt == MAX_C);
  assign epi_next    = epi_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      init_st     <= '0;
      cur_st      <= '0;
      act_r       <= '0;
      nst_r       <= '0;
      rt_r        <= '0;
      step_cnt    <= '0;
      epi_cnt     <= '0;
      act_req_r   <= 1'b0;
      upd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            init_st   <= i_init_state;
            cur_st    <= i_init_state;
            step_cnt  <= '0;
            epi_cnt   <= '0;
            act_req_r <= 1'b1;
            busy_r    <= 1'b1;
            state     <= S_ACT;
          end
        end

        // nst_r doubles as the ROM address, so it only moves on this edge and
        // the ROM gets the whole RWD cycle to settle.
        S_ACT: begin
          if (i_act_valid) begin
            act_r     <= i_action;
            nst_r     <= i_next_st;
            act_req_r <= 1'b0;
            state     <= S_RWD;
          end
        end

        S_RWD: begin
          rt_r        <= i_rom_rt;
          upd_valid_r <= 1'b1;
          state       <= S_UPD;
        end

        // Payload registers are not touched here, so they stay stable for
        // however long the update unit stalls.
        S_UPD: begin
          if (i_upd_ready) begin
            upd_valid_r <= 1'b0;
            step_cnt    <= step_cnt + 1'b1;
            state       <= S_CHK;
          end
        end

        S_CHK: begin
          if (episode_end) begin
            epi_cnt  <= epi_next;
            step_cnt <= '0;
            if (epi_next == NUM_C) begin
              done_r <= 1'b1;
              state  <= S_DONE;
            end else begin
              cur_st    <= init_st;
              act_req_r <= 1'b1;
              state     <= S_ACT;
            end
          end else begin
            cur_st    <= nst_r;
            act_req_r <= 1'b1;
            state     <= S_ACT;
          end
        end

        // Busy stays high through DONE and falls together with o_done.
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          act_req_r   <= 1'b0;
          upd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign o_act_req   = act_req_r;
  assign o_cur_st    = cur_st;
  assign o_rom_st    = nst_r;
  assign o_upd_valid = upd_valid_r;
  assign o_upd_st    = cur_st;
  assign o_upd_act   = act_r;
  assign o_upd_nst   = nst_r;
  assign o_upd_rt    = rt_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_step_cnt  = step_cnt;
  assign o_epi_cnt   = epi_cnt;

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// tb/tb_qlearn_episode_ctrl.sv - scoreboard bench for qlearn_episode_ctrl

module tb_qlearn_episode_ctrl;

  localparam int SW    = 4;
  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int MAXS  = 4;
  localparam int NEPI  = 3;
  localparam int GOAL  = 15;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [SW-1:0] i_init_state;
  logic          o_act_req;
  logic [SW-1:0] o_cur_st;
  logic          i_act_valid;
  logic [AW-1:0] i_action;
  logic [SW-1:0] i_next_st;
  logic [SW-1:0] o_rom_st;
  logic [DW-1:0] i_rom_rt;
  logic          o_upd_valid;
  logic          i_upd_ready;
  logic [SW-1:0] o_upd_st;
  logic [AW-1:0] o_upd_act;
  logic [SW-1:0] o_upd_nst;
  logic [DW-1:0] o_upd_rt;
  logic          o_busy;
  logic          o_done;
  logic [7:0]    o_step_cnt;
  logic [7:0]    o_epi_cnt;

  qlearn_episode_ctrl #(
    .STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .DATA_WIDTH(DW),
    .STEP_WIDTH(8), .EPI_WIDTH(8),
    .MAX_STEPS(MAXS), .NUM_EPISODES(NEPI), .GOAL_STATE(GOAL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_init_state(i_init_state),
    .o_act_req(o_act_req), .o_cur_st(o_cur_st), .i_act_valid(i_act_valid),
    .i_action(i_action), .i_next_st(i_next_st), .o_rom_st(o_rom_st), .i_rom_rt(i_rom_rt),
    .o_upd_valid(o_upd_valid), .i_upd_ready(i_upd_ready), .o_upd_st(o_upd_st),
    .o_upd_act(o_upd_act), .o_upd_nst(o_upd_nst), .o_upd_rt(o_upd_rt),
    .o_busy(o_busy), .o_done(o_done), .o_step_cnt(o_step_cnt), .o_epi_cnt(o_epi_cnt)
  );

  typedef struct {
    logic [SW-1:0] st;
    logic [AW-1:0] act;
    logic [SW-1:0] nst;
    logic [DW-1:0] rt;
    int            step;
    int            epi;
  } tup_t;

  tup_t exp_q[$];
  int   done_q[$];

  logic [DW-1:0] rom [16];
  assign i_rom_rt = rom[o_rom_st];

  int total = 0;
  int bad   = 0;

  // Reference model of one run, advanced at the moment each step is issued.
  int model_init, model_cur, model_step, model_epi, model_last_nst, model_run_steps;
  int act_delay_mode = 0;  // 0: none, 1: random 0..3, 2: fixed 3
  int ready_mode     = 0;  // 0: always, 1: random 0..3 stall, 2: stall 5, 3: never
  int pol_wait       = 0;
  int rdy_hold       = 0;
  int cyc            = 0;
  int act_cyc        = 0;
  int done_cyc       = 0;
  int done_seen      = 0;

  logic          have_stall;
  logic          prev_done;
  tup_t          stall_t;
  int            stall_step;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int calc_wait(input int mode);
    if (mode == 1) return $urandom_range(0, 3);
    if (mode == 2) return 3;
    return 0;
  endfunction

  function automatic int calc_hold(input int mode);
    if (mode == 1) return $urandom_range(0, 3);
    if (mode == 2) return 5;
    if (mode == 3) return 100000;
    return 0;
  endfunction

  // Policy/environment responder.
  initial begin : policy_drv
    tup_t t;
    int   a, n;
    i_act_valid = 1'b0;
    i_action    = '0;
    i_next_st   = '0;
    forever begin
      @(posedge i_clk);
      #1;
      i_act_valid = 1'b0;
      if (o_act_req) begin
        check("act_rom_hold", 32'(o_rom_st), 32'(model_last_nst));
        if (pol_wait > 0) begin
          pol_wait--;
        end else begin
          check("act_cur_st", 32'(o_cur_st), 32'(model_cur));
          check("act_step_cnt", 32'(o_step_cnt), 32'(model_step));
          check("act_epi_cnt", 32'(o_epi_cnt), 32'(model_epi));
          a = $urandom_range(0, 3);
          n = ($urandom_range(0, 3) == 0) ? GOAL : $urandom_range(0, 14);
          t.st   = SW'(model_cur);
          t.act  = AW'(a);
          t.nst  = SW'(n);
          t.rt   = rom[n];
          t.step = model_step;
          t.epi  = model_epi;
          exp_q.push_back(t);
          i_action    = AW'(a);
          i_next_st   = SW'(n);
          i_act_valid = 1'b1;
          model_last_nst = n;
          model_run_steps++;
          model_step++;
          if (n == GOAL || model_step == MAXS) begin
            model_epi++;
            model_step = 0;
            model_cur  = model_init;
            if (model_epi == NEPI) done_q.push_back(NEPI);
          end else begin
            model_cur = n;
          end
          pol_wait = calc_wait(act_delay_mode);
        end
      end
    end
  end

  // Update-unit ready driver; ready toggles randomly outside UPD.
  initial begin : ready_drv
    i_upd_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_upd_valid) begin
        if (rdy_hold > 0) begin
          i_upd_ready = 1'b0;
          rdy_hold--;
        end else begin
          i_upd_ready = 1'b1;
        end
      end else begin
        i_upd_ready = 1'($urandom_range(0, 1));
        rdy_hold    = calc_hold(ready_mode);
      end
    end
  end

  // Monitor: pops the scoreboard on every update transfer and on o_done.
  initial begin : monitor
    tup_t e;
    have_stall = 1'b0;
    prev_done  = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_upd_valid) begin
          if (have_stall) begin
            check("stall_st", 32'(o_upd_st), 32'(stall_t.st));
            check("stall_act", 32'(o_upd_act), 32'(stall_t.act));
            check("stall_nst", 32'(o_upd_nst), 32'(stall_t.nst));
            check("stall_rt", 32'(o_upd_rt), 32'(stall_t.rt));
            check("stall_step", 32'(o_step_cnt), 32'(stall_step));
          end
          if (i_upd_ready) begin
            have_stall = 1'b0;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL upd_unexpected: got tuple st=%0d nst=%0d with none pending", o_upd_st, o_upd_nst);
            end else begin
              e = exp_q.pop_front();
              check("upd_st", 32'(o_upd_st), 32'(e.st));
              check("upd_act", 32'(o_upd_act), 32'(e.act));
              check("upd_nst", 32'(o_upd_nst), 32'(e.nst));
              check("upd_rt", 32'(o_upd_rt), 32'(e.rt));
              check("upd_step", 32'(o_step_cnt), 32'(e.step));
              check("upd_epi", 32'(o_epi_cnt), 32'(e.epi));
            end
          end else begin
            have_stall      = 1'b1;
            stall_t.st      = o_upd_st;
            stall_t.act     = o_upd_act;
            stall_t.nst     = o_upd_nst;
            stall_t.rt      = o_upd_rt;
            stall_step      = int'(o_step_cnt);
          end
        end else begin
          have_stall = 1'b0;
        end
        if (prev_done) begin
          check("done_one_cycle", 32'(o_done), 32'd0);
          check("busy_after_done", 32'(o_busy), 32'd0);
        end
        prev_done = o_done;
        if (o_done) begin
          done_seen++;
          done_cyc = cyc;
          if (done_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got o_done=1 with no run end pending");
          end else begin
            check("done_epi_cnt", 32'(o_epi_cnt), 32'(done_q.pop_front()));
          end
          check("done_step_cnt", 32'(o_step_cnt), 32'd0);
          check("done_busy", 32'(o_busy), 32'd1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_act_req"}, 32'(o_act_req), 0);
    check({tag, "_upd_valid"}, 32'(o_upd_valid), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_step"}, 32'(o_step_cnt), 0);
    check({tag, "_epi"}, 32'(o_epi_cnt), 0);
    check({tag, "_cur_st"}, 32'(o_cur_st), 0);
    check({tag, "_rom_st"}, 32'(o_rom_st), 0);
    check({tag, "_upd_tuple"}, {o_upd_act, o_upd_nst, o_upd_rt}, 0);
  endtask

  task automatic start_run(input int init);
    @(posedge i_clk);
    #1;
    model_init      = init;
    model_cur       = init;
    model_step      = 0;
    model_epi       = 0;
    model_run_steps = 0;
    pol_wait        = calc_wait(act_delay_mode);
    i_init_state    = SW'(init);
    i_start         = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    act_cyc = cyc;
    check("start_act_req", 32'(o_act_req), 1);
    check("start_busy", 32'(o_busy), 1);
  endtask

  task automatic wait_done(input string tag);
    int seen0;
    bit ok;
    seen0 = done_seen;
    ok    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge i_clk);
      if (done_seen > seen0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no o_done within 3000 cycles, expected run end", tag);
    end
    repeat (3) @(posedge i_clk);
    #1;
    check({tag, "_leftover_upd"}, 32'(exp_q.size()), 0);
    check({tag, "_final_epi"}, 32'(o_epi_cnt), NEPI);
    check({tag, "_final_busy"}, 32'(o_busy), 0);
  endtask

  initial begin : main
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_init_state = '0;
    model_last_nst = 0;
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);

    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      check("idle_busy", 32'(o_busy), 0);
      check("idle_act_req", 32'(o_act_req), 0);
    end

    // Zero-wait run: every step is exactly four cycles.
    act_delay_mode = 0;
    ready_mode     = 0;
    start_run($urandom_range(0, 14));
    wait_done("zero_wait");
    check("zero_wait_cycles", 32'(done_cyc - act_cyc), 32'(4 * model_run_steps));

    // Random waits on both handshakes, plus a start pulse while busy.
    act_delay_mode = 1;
    ready_mode     = 1;
    start_run($urandom_range(0, 14));
    repeat (5) @(posedge i_clk);
    #1;
    check("busy_before_restart", 32'(o_busy), 1);
    i_init_state = SW'($urandom_range(0, 14));
    i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done("random_wait");

    // Fixed late action (3 cycles) and 5-cycle update backpressure.
    act_delay_mode = 2;
    ready_mode     = 2;
    start_run($urandom_range(0, 14));
    wait_done("backpressure");

    // Reset while the update tuple is stalled.
    act_delay_mode = 0;
    ready_mode     = 3;
    start_run($urandom_range(0, 14));
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge i_clk);
        if (o_upd_valid) begin
          got = 1'b1;
          break;
        end
      end
      check("reset_upd_reached", 32'(got), 1);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    done_q.delete();
    model_last_nst = 0;
    have_stall     = 1'b0;
    prev_done      = 1'b0;
    ready_mode     = 0;
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;

    act_delay_mode = 1;
    ready_mode     = 1;
    start_run($urandom_range(0, 14));
    check("clean_start_epi", 32'(o_epi_cnt), 0);
    wait_done("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
